// File: rtl/fwft_byte_packer_pkg.sv
// Shared types and constants for the FWFT byte packer.
package compair_packer_pkg;

  // Packer control states: gathering bytes, or presenting a finished word.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Link idle symbol that may be dropped from the byte stream.
  localparam logic [7:0] IDLE_BYTE        = 8'hBC;
  // Default filler for unused lanes of a timed-out partial word.
  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'hFF;

endpackage : compair_packer_pkg

// File: rtl/fwft_byte_packer_flush_timer.sv
// Idle timer for the byte packer: counts enabled cycles and flags expiry
// on the cycle it reaches TIMEOUT-1. With TIMEOUT=0 it never expires.
module packer_flush_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    // Flushing disabled: no counter, expiry tied low.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, enable};
    assign expire        = 1'b0;
  end else begin : g_on
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    // Count idle cycles; any clear (pop or flush) restarts from zero.
    always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values of the others.
      if (rst || clear) begin
        timer <= '0;
      end else if (enable) begin
        timer <= timer + TW'(1);
      end
    end

    assign expire = enable && (timer == TW'(TIMEOUT - 1));
  end

endmodule : packer_flush_timer

// File: rtl/fwft_byte_packer.sv
// FWFT byte packer: pops bytes from a first-word-fall-through FIFO head and
// packs BYTES_PER_WORD of them MSB-first into a word on a valid/ready port.
// A partial word left idle for TIMEOUT cycles is flushed with PAD_BYTE lanes.
// Optional: define FWFT_PACKER_IDLE_DROP_EN to consume IDLE_BYTE without
// packing it.
module fwft_byte_packer
  import compair_packer_pkg::*;
#(
  parameter int         BYTES_PER_WORD = 4,
  parameter int         TIMEOUT        = 64,
  parameter logic [7:0] PAD_BYTE       = DEFAULT_PAD_BYTE
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fifo_empty,
  input  logic [7:0]                           fifo_data,
  output logic                                 fifo_read,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [8*BYTES_PER_WORD-1:0]          word_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_nbytes,
  output logic                                 word_flushed
);

  localparam int             CW   = $clog2(BYTES_PER_WORD + 1);
  localparam int             WW   = 8 * BYTES_PER_WORD;
  localparam logic [CW-1:0]  LAST = CW'(BYTES_PER_WORD - 1);

  state_e         state, state_next;
  logic [CW-1:0]  count;
  logic [WW-1:0]  acc, acc_next, flush_word;
  logic           is_idle, pack, complete, flush_go, handshake;
  logic           timer_clear, timer_enable, timer_expire;

  assign handshake = (state == HOLD) && word_valid && word_ready;

  // Pop whenever filling, or in the cycle that hands off the held word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    fifo_read = 1'b0;
    if (!rst && !fifo_empty) begin
      fifo_read = (state == FILL) || handshake;
    end
  end

`ifdef FWFT_PACKER_IDLE_DROP_EN
  assign is_idle = (fifo_data == IDLE_BYTE);
`else
  assign is_idle = 1'b0;
`endif

  // A popped idle byte is consumed but neither packed nor counted.
  assign pack     = fifo_read && !is_idle;
  assign complete = pack && (count == LAST);
  assign flush_go = (state == FILL) && timer_expire;

  // The timer runs only with a partial word waiting on an empty FIFO, so a
  // pop in the would-be expiry cycle always wins over the flush.
  assign timer_enable = (state == FILL) && (count != '0) && fifo_empty;
  assign timer_clear  = pack || flush_go;

  packer_flush_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_flush_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: leave FILL on a full word or a flush, leave HOLD on handshake.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (complete || flush_go) state_next = HOLD;
      HOLD:    if (handshake)            state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Lane packing: byte number n lands in lane BYTES_PER_WORD-1-n; the flush
  // image pads every lane not yet written.
  always_comb begin
    acc_next   = acc;
    flush_word = acc;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (pack && (count == CW'(BYTES_PER_WORD - 1 - i))) begin
        acc_next[8*i +: 8] = fifo_data;
      end
      if (CW'(BYTES_PER_WORD - 1 - i) >= count) begin
        flush_word[8*i +: 8] = PAD_BYTE;
      end
    end
  end

  // Byte count for the word being gathered; wraps only on completion/flush.
  always_ff @(posedge clk) begin
    if (rst || complete || flush_go) begin
      count <= '0;
    end else if (pack) begin
      count <= count + CW'(1);
    end
  end

  // Assembly register for the word being gathered.
  always_ff @(posedge clk) begin
    // NOTE: this datapath register has no reset; lanes are always rewritten
    // or padded before they can reach word_data, so stale bytes never leak.
    acc <= acc_next;
  end

  // Output word register: loaded on completion or flush, held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid   <= 1'b0;
      word_data    <= '0;
      word_nbytes  <= '0;
      word_flushed <= 1'b0;
    end else if (complete) begin
      word_valid   <= 1'b1;
      word_data    <= acc_next;
      word_nbytes  <= CW'(BYTES_PER_WORD);
      word_flushed <= 1'b0;
    end else if (flush_go) begin
      word_valid   <= 1'b1;
      word_data    <= flush_word;
      word_nbytes  <= count;
      word_flushed <= 1'b1;
    end else if (handshake) begin
      word_valid   <= 1'b0;
    end
  end

endmodule : fwft_byte_packer
